// File: rtl/servo_pwm_multi_if.sv
// rtl/servo_pwm_multi_if.sv - position write port of the multi-channel servo PWM generator
interface servo_pwm_multi_if #(
  parameter int CH_W  = 2,
  parameter int POS_W = 10
);
  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_ch;
  logic [POS_W-1:0] wr_pos;
  logic             wr_err;

  modport master (output wr_valid, wr_ch, wr_pos, input wr_ready, wr_err);
  modport slave  (input wr_valid, wr_ch, wr_pos, output wr_ready, wr_err);
endinterface

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - N-channel servo PWM with shared frame counter and per-frame slew limiting
module servo_pwm_multi #(
  parameter int N_CH          = 4,
  parameter int POS_W         = 10,
  parameter int POS_MAX       = 1000,
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int MIN_PULSE     = 25_000,
  parameter int PULSE_LSB     = 100,
  parameter int STEP_CYCLES   = 500,
  parameter int CNT_W         = $clog2(PERIOD_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  servo_pwm_multi_if.slave   wr,
  output logic [N_CH-1:0]    pwm_out,
  output logic               frame_start,
  output logic [N_CH-1:0]    slewing
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  // One extra bit so a width equal to PERIOD_CYCLES still fits.
  localparam int WID_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [WID_W-1:0] W_MIN    = WID_W'(MIN_PULSE);
  localparam logic [WID_W-1:0] W_LSB    = WID_W'(PULSE_LSB);
  localparam logic [WID_W-1:0] W_STEP   = WID_W'(STEP_CYCLES);
  localparam logic [POS_W-1:0] P_MAX    = POS_W'(POS_MAX);

  logic [CNT_W-1:0] cnt;
  logic [WID_W-1:0] target [N_CH];
  logic [WID_W-1:0] live   [N_CH];
  logic [POS_W-1:0] pos_cl;
  logic [WID_W-1:0] wr_width;
  logic             wr_fire;
  logic             ch_ok;
  logic             boundary;

  function automatic logic [WID_W-1:0] slew_next(input logic [WID_W-1:0] l,
                                                 input logic [WID_W-1:0] t);
    if (STEP_CYCLES == 0) return t;
    if (t >= l) return ((t - l) <= W_STEP) ? t : l + W_STEP;
    return ((l - t) <= W_STEP) ? t : l - W_STEP;
  endfunction

  assign wr.wr_ready = ~rst;
  assign wr_fire     = wr.wr_valid & wr.wr_ready;
  assign ch_ok       = int'(wr.wr_ch) < N_CH;
  // Clamp before the multiply so the product never exceeds the width register.
  assign pos_cl      = (wr.wr_pos > P_MAX) ? P_MAX : wr.wr_pos;
  assign wr_width    = W_MIN + WID_W'(pos_cl) * W_LSB;
  assign boundary    = en && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en)             cnt <= '0;
    else if (cnt == CNT_LAST)   cnt <= '0;
    else                        cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wr.wr_err <= 1'b0;
    else     wr.wr_err <= wr_fire & ~ch_ok;
  end

  // Live only moves on the frame boundary, using the target as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst) begin
        target[i] <= W_MIN;
        live[i]   <= W_MIN;
      end else begin
        if (wr_fire && ch_ok && (wr.wr_ch == CH_W'(i))) target[i] <= wr_width;
        if (boundary) live[i] <= slew_next(live[i], target[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out     <= '0;
      frame_start <= 1'b0;
      slewing     <= '0;
    end else begin
      frame_start <= en && (cnt == '0);
      for (int i = 0; i < N_CH; i++) begin
        pwm_out[i] <= en && ({1'b0, cnt} < live[i]);
        slewing[i] <= live[i] != target[i];
      end
    end
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - directed self-checking bench for servo_pwm_multi
module tb_servo_pwm_multi;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] pwm_a, slew_a;
  logic       fs_a;
  logic [2:0] pwm_b, slew_b;
  logic       fs_b;

  int n_assert = 0;
  int n_fail   = 0;
  int w0, w1, v0, v1, v2, fs_n;

  always #5 clk = ~clk;

  servo_pwm_multi_if #(.CH_W(1), .POS_W(10)) wa ();
  servo_pwm_multi_if #(.CH_W(2), .POS_W(10)) wb ();

  servo_pwm_multi #(
    .N_CH(2), .POS_W(10), .POS_MAX(50), .PERIOD_CYCLES(100),
    .MIN_PULSE(10), .PULSE_LSB(1), .STEP_CYCLES(5)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .wr(wa),
    .pwm_out(pwm_a), .frame_start(fs_a), .slewing(slew_a)
  );

  // Unlimited-slew variant; three channels so an out-of-range channel is encodable.
  servo_pwm_multi #(
    .N_CH(3), .POS_W(10), .POS_MAX(50), .PERIOD_CYCLES(100),
    .MIN_PULSE(10), .PULSE_LSB(1), .STEP_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .wr(wb),
    .pwm_out(pwm_b), .frame_start(fs_b), .slewing(slew_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!fs_a && n < 250) begin
      tick();
      n++;
    end
    chk("wait_frame_start", int'(fs_a), 1);
  endtask

  task automatic measure(input int wr_at, input logic wch, input logic [9:0] wpos);
    w0 = 0; w1 = 0; v0 = 0; v1 = 0; v2 = 0; fs_n = 0;
    for (int i = 0; i < 100; i++) begin
      w0   += int'(pwm_a[0]);
      w1   += int'(pwm_a[1]);
      v0   += int'(pwm_b[0]);
      v1   += int'(pwm_b[1]);
      v2   += int'(pwm_b[2]);
      fs_n += int'(fs_a);
      if (i == wr_at) begin
        wa.wr_valid = 1'b1;
        wa.wr_ch    = wch;
        wa.wr_pos   = wpos;
      end else begin
        wa.wr_valid = 1'b0;
      end
      tick();
    end
    wa.wr_valid = 1'b0;
  endtask

  int exp0 [10] = '{45, 50, 55, 60, 60, 60, 60, 60, 60, 60};
  int exp1 [10] = '{20, 25, 30, 35, 40, 45, 50, 55, 60, 60};

  initial begin
    rst = 1'b1; en = 1'b0;
    wa.wr_valid = 1'b0; wa.wr_ch = 1'b0; wa.wr_pos = '0;
    wb.wr_valid = 1'b0; wb.wr_ch = 2'd0; wb.wr_pos = '0;
    repeat (3) tick();
    chk("rst_pwm", int'(pwm_a), 0);
    chk("rst_fs", int'(fs_a), 0);
    chk("rst_slew", int'(slew_a), 0);
    chk("rst_wr_err", int'(wa.wr_err), 0);
    chk("rst_wr_ready", int'(wa.wr_ready), 0);

    rst = 1'b0;
    tick();
    chk("idle_wr_ready", int'(wa.wr_ready), 1);
    chk("idle_pwm_en0", int'(pwm_a), 0);

    en = 1'b1;
    wait_fs();
    for (int f = 0; f < 2; f++) begin
      measure(-1, 1'b0, 10'd0);
      chk($sformatf("base_w0_f%0d", f), w0, 10);
      chk($sformatf("base_w1_f%0d", f), w1, 10);
      chk($sformatf("base_fs_f%0d", f), fs_n, 1);
    end

    // ch0 pos 30 -> target 40, slews 5 per frame
    measure(0, 1'b0, 10'd30);
    chk("wr30_cur_w0", w0, 10);
    chk("wr30_slew", int'(slew_a), 1);
    for (int f = 0; f < 6; f++) begin
      measure(-1, 1'b0, 10'd0);
      chk($sformatf("slew_w0_f%0d", f), w0, 15 + 5 * f);
      chk($sformatf("slew_w1_f%0d", f), w1, 10);
    end
    measure(-1, 1'b0, 10'd0);
    chk("steady_w0", w0, 40);
    chk("steady_slew", int'(slew_a), 0);
    chk("no_err_legal", int'(wa.wr_err), 0);

    // ch1 pos 200 clamps to 50 -> target 60; then ch0 pos 50 written mid-frame
    measure(10, 1'b1, 10'd200);
    chk("clamp_cur_w0", w0, 40);
    chk("clamp_cur_w1", w1, 10);
    chk("clamp_slew", int'(slew_a), 2);
    measure(30, 1'b0, 10'd50);
    chk("mid_cur_w0", w0, 40);
    chk("mid_cur_w1", w1, 15);
    for (int f = 0; f < 10; f++) begin
      measure(-1, 1'b0, 10'd0);
      chk($sformatf("tbl_w0_f%0d", f), w0, exp0[f]);
      chk($sformatf("tbl_w1_f%0d", f), w1, exp1[f]);
    end
    chk("tbl_slew_done", int'(slew_a), 0);

    // en drop mid-pulse, then re-raise
    repeat (20) tick();
    chk("pre_drop_pwm", int'(pwm_a), 3);
    en = 1'b0;
    tick();
    chk("drop_pwm", int'(pwm_a), 0);
    chk("drop_fs", int'(fs_a), 0);
    repeat (5) tick();
    chk("held_pwm", int'(pwm_a), 0);
    chk("held_fs", int'(fs_a), 0);
    en = 1'b1;
    tick();
    chk("reen_fs", int'(fs_a), 1);
    measure(-1, 1'b0, 10'd0);
    chk("reen_w0", w0, 60);
    chk("reen_w1", w1, 60);
    chk("reen_fs_n", fs_n, 1);

    // reset mid-frame
    repeat (5) tick();
    chk("pre_rst_pwm", int'(pwm_a), 3);
    rst = 1'b1;
    tick();
    chk("midrst_pwm", int'(pwm_a), 0);
    chk("midrst_ready", int'(wa.wr_ready), 0);
    chk("midrst_fs", int'(fs_a), 0);
    rst = 1'b0;
    wait_fs();
    measure(-1, 1'b0, 10'd0);
    chk("postrst_w0", w0, 10);
    chk("postrst_w1", w1, 10);
    chk("postrst_v0", v0, 10);

    // unlimited-slew variant: legal write, then out-of-range channel
    wb.wr_valid = 1'b1; wb.wr_ch = 2'd0; wb.wr_pos = 10'd40;
    tick();
    wb.wr_valid = 1'b0;
    chk("b_legal_err", int'(wb.wr_err), 0);
    wb.wr_valid = 1'b1; wb.wr_ch = 2'd3; wb.wr_pos = 10'd20;
    tick();
    wb.wr_valid = 1'b0;
    chk("b_bad_err", int'(wb.wr_err), 1);
    tick();
    chk("b_err_pulse", int'(wb.wr_err), 0);
    wait_fs();
    measure(-1, 1'b0, 10'd0);
    chk("b_jump_v0", v0, 50);
    chk("b_keep_v1", v1, 10);
    chk("b_keep_v2", v2, 10);
    chk("b_slew", int'(slew_b), 0);
    chk("a_unchanged_w0", w0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
